// File: rtl/fp_exc_pkg.sv
// rtl/fp_exc_pkg.sv - operand classes, flag indices and canonical FP constants
package fp_exc_pkg;

  typedef enum logic [1:0] {ZERO, INF, NAN, NORM} fp_class_t;

  localparam int FLAG_W       = 6;
  localparam int FLAG_ZERO    = 5;
  localparam int FLAG_INF     = 4;
  localparam int FLAG_NAN     = 3;
  localparam int FLAG_TINY    = 2;
  localparam int FLAG_HUGE    = 1;
  localparam int FLAG_INEXACT = 0;

  // Constants are built at a generous fixed width and sliced by the user.
  localparam int FP_MAX_W = 128;
  localparam logic [FP_MAX_W-1:0] FP_ONE = {{(FP_MAX_W-1){1'b0}}, 1'b1};

  function automatic logic [FP_MAX_W-1:0] fp_exp_ones(input int exp_w);
    return (FP_ONE << exp_w) - FP_ONE;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
    return fp_exp_ones(exp_w) << man_w;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (FP_ONE << (man_w - 1));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_maxnorm(input int exp_w, input int man_w);
    return ((fp_exp_ones(exp_w) - FP_ONE) << man_w) | ((FP_ONE << man_w) - FP_ONE);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_minnorm(input int man_w);
    return FP_ONE << man_w;
  endfunction

endpackage

// File: rtl/round_enum_pkg.sv
// rtl/round_enum_pkg.sv - rounding mode enumeration shared by the FP multiplier datapath
package round_enum_pkg;

  typedef enum logic [2:0] {
    IEEE_near,
    IEEE_zero,
    IEEE_pinf,
    IEEE_ninf,
    near_up,
    away_zero
  } round_values;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational class decode of one FP word (denormals read as ZERO)
module fp_classify
  import fp_exc_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] man_i,
  output fp_class_t        cls_o
);

  always_comb begin
    cls_o = NORM;
    if (exp_i == '0)
      cls_o = ZERO;
    else if (&exp_i)
      cls_o = (man_i == '0) ? INF : NAN;
  end

endmodule

// File: rtl/fp_mult_exception_pipe.sv
// rtl/fp_mult_exception_pipe.sv - two-stage FP multiply exception/status stage; FP_NAN_PROPAGATE_EN enables NaN payload propagation
module fp_mult_exception_pipe
  import fp_exc_pkg::*;
  import round_enum_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [W-1:0]      z_calc,
  input  logic              overflow,
  input  logic              underflow,
  input  logic              inexact,
  input  round_values       round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      z,
  output logic [FLAG_W-1:0] flags,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              sticky_clr
);

  localparam logic [FP_MAX_W-1:0] INF_X  = fp_inf(EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] QNAN_X = fp_qnan(EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] MAXN_X = fp_maxnorm(EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] MINN_X = fp_minnorm(MAN_W);
  localparam logic [W-2:0]        INF_M  = INF_X[W-2:0];
  localparam logic [W-2:0]        MAXN_M = MAXN_X[W-2:0];
  localparam logic [W-2:0]        MINN_M = MINN_X[W-2:0];
  localparam logic [W-1:0]        QNAN   = QNAN_X[W-1:0];
`ifdef FP_NAN_PROPAGATE_EN
  localparam logic [W-1:0]        QBIT   = {{(W-MAN_W){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};
`endif

  fp_class_t ca_c, cb_c, cz_c;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp_i(a[W-2:MAN_W]), .man_i(a[MAN_W-1:0]), .cls_o(ca_c));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp_i(b[W-2:MAN_W]), .man_i(b[MAN_W-1:0]), .cls_o(cb_c));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_z (
    .exp_i(z_calc[W-2:MAN_W]), .man_i(z_calc[MAN_W-1:0]), .cls_o(cz_c));

  logic        v1_q, v2_q;
  fp_class_t   ca_q, cb_q, cz_q;
  logic        s_q, ovf_q, unf_q, inx_q;
  logic [W-1:0] zc_q;
  round_values rnd_q;
`ifdef FP_NAN_PROPAGATE_EN
  logic [W-1:0] a_q, b_q;
`endif
  logic [W-1:0]      z_d, z_q;
  logic [FLAG_W-1:0] flags_d, flags_q, sticky_q;
  logic adv1, adv2, to_inf, to_min, tiny;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      ca_q  <= ZERO;
      cb_q  <= ZERO;
      cz_q  <= ZERO;
      s_q   <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
      zc_q  <= '0;
      rnd_q <= IEEE_near;
`ifdef FP_NAN_PROPAGATE_EN
      a_q   <= '0;
      b_q   <= '0;
`endif
    end else if (adv1) begin
      v1_q  <= in_valid;
      ca_q  <= ca_c;
      cb_q  <= cb_c;
      cz_q  <= cz_c;
      s_q   <= a[W-1] ^ b[W-1];
      ovf_q <= overflow;
      unf_q <= underflow;
      inx_q <= inexact;
      zc_q  <= z_calc;
      rnd_q <= round;
`ifdef FP_NAN_PROPAGATE_EN
      a_q   <= a;
      b_q   <= b;
`endif
    end
  end

  // Directed rounding picks the finite extreme when rounding toward the sign's far side.
  assign to_inf = (rnd_q == IEEE_zero) ? 1'b0 :
                  (rnd_q == IEEE_pinf) ? !s_q :
                  (rnd_q == IEEE_ninf) ? s_q  : 1'b1;
  assign to_min = (rnd_q == away_zero) || (rnd_q == IEEE_pinf && !s_q) ||
                  (rnd_q == IEEE_ninf && s_q);
  assign tiny   = unf_q || (zc_q[MAN_W-1:0] != '0);

  always_comb begin
    z_d     = zc_q;
    flags_d = '0;
    if (ca_q == NAN || cb_q == NAN || (ca_q == ZERO && cb_q == INF) ||
        (ca_q == INF && cb_q == ZERO)) begin
      z_d = QNAN;
      flags_d[FLAG_NAN] = 1'b1;
`ifdef FP_NAN_PROPAGATE_EN
      if (ca_q == NAN)
        z_d = a_q | QBIT;
      else if (cb_q == NAN)
        z_d = b_q | QBIT;
`endif
    end else if (ca_q == INF || cb_q == INF) begin
      z_d = {s_q, INF_M};
      flags_d[FLAG_INF] = 1'b1;
    end else if (ca_q == ZERO || cb_q == ZERO) begin
      z_d = {s_q, {(W-1){1'b0}}};
      flags_d[FLAG_ZERO] = 1'b1;
    end else begin
      flags_d[FLAG_INEXACT] = inx_q || ovf_q || unf_q;
      if (ovf_q) begin
        z_d = to_inf ? {s_q, INF_M} : {s_q, MAXN_M};
        flags_d[FLAG_HUGE] = 1'b1;
        flags_d[FLAG_INF]  = to_inf;
      end else if (unf_q || cz_q == ZERO) begin
        z_d = to_min ? {s_q, MINN_M} : {s_q, {(W-1){1'b0}}};
        flags_d[FLAG_ZERO] = !to_min;
        flags_d[FLAG_TINY] = tiny;
      end else if (cz_q != NORM) begin
        z_d = {s_q, INF_M};
        flags_d[FLAG_INF]  = 1'b1;
        flags_d[FLAG_HUGE] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q     <= 1'b0;
      z_q      <= '0;
      flags_q  <= '0;
      sticky_q <= '0;
    end else begin
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          z_q     <= z_d;
          flags_q <= flags_d;
        end
      end
      // Clear takes effect before the accepted result's flags are merged in.
      if (v2_q && out_ready)
        sticky_q <= (sticky_clr ? '0 : sticky_q) | flags_q;
      else if (sticky_clr)
        sticky_q <= '0;
    end
  end

  assign out_valid    = v2_q;
  assign z            = z_q;
  assign flags        = flags_q;
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_mult_exception_pipe.sv
// tb/tb_fp_mult_exception_pipe.sv - self-checking bench for fp_mult_exception_pipe (FP32)
module tb_fp_mult_exception_pipe;
  import round_enum_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic        ovf = 1'b0, unf = 1'b0, inx = 1'b0, sticky_clr = 1'b0;
  logic [31:0] a = '0, b = '0, zc = '0, z;
  logic [5:0]  flags, sticky;
  round_values rnd = IEEE_near;

  int pass_cnt = 0, total_cnt = 0;
  logic [37:0] exp_q[$];
  logic [5:0]  sticky_m = '0;

  always #5 clk = ~clk;

  fp_mult_exception_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .z_calc(zc), .overflow(ovf), .underflow(unf), .inexact(inx),
    .round(rnd), .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .flags(flags), .sticky_flags(sticky), .sticky_clr(sticky_clr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction
  function automatic bit is_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 0;
  endfunction
  function automatic bit is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  // Flag order {zero, inf, nan, tiny, huge, inexact}; result packed as {z, flags}.
  function automatic logic [37:0] ref_model(input logic [31:0] fa, fb, fz,
                                            input logic ov, un, ix, input round_values m);
    logic s, ie, tn, up, inf_res;
    s  = fa[31] ^ fb[31];
    ie = ix | ov | un;
    if (is_nan(fa) || is_nan(fb) || (is_zero(fa) && is_inf(fb)) || (is_inf(fa) && is_zero(fb))) begin
`ifdef FP_NAN_PROPAGATE_EN
      if (is_nan(fa)) return {fa | 32'h0040_0000, 6'b001000};
      if (is_nan(fb)) return {fb | 32'h0040_0000, 6'b001000};
`endif
      return {32'h7FC0_0000, 6'b001000};
    end
    if (is_inf(fa) || is_inf(fb)) return {s, 31'h7F80_0000, 6'b010000};
    if (is_zero(fa) || is_zero(fb)) return {s, 31'h0, 6'b100000};
    if (ov) begin
      case (m)
        IEEE_zero: inf_res = 1'b0;
        IEEE_pinf: inf_res = (s == 1'b0);
        IEEE_ninf: inf_res = (s == 1'b1);
        default:   inf_res = 1'b1;
      endcase
      if (inf_res) return {s, 31'h7F80_0000, 5'b01001, ie};
      return {s, 31'h7F7F_FFFF, 5'b00001, ie};
    end
    if (un || is_zero(fz)) begin
      tn = un ? 1'b1 : (fz[22:0] != 0);
      up = (m == away_zero) || (m == IEEE_pinf && !s) || (m == IEEE_ninf && s);
      if (up) return {s, 31'h0080_0000, 3'b000, tn, 1'b0, ie};
      return {s, 31'h0, 3'b100, tn, 1'b0, ie};
    end
    if (fz[30:23] == 8'hFF) return {s, 31'h7F80_0000, 5'b01001, ie};
    return {fz, 5'b00000, ie};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic sg;
    sg = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       return {sg, 8'h00, 23'($urandom)};
      1:       return {sg, 8'hFF, 23'h0};
      2:       return {sg, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: return {sg, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Scoreboard: expectations enter on input handshakes, leave on output handshakes.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sticky_m = '0;
    end else begin
      chk("sticky_flags", 64'(sticky), 64'(sticky_m));
      chk("spurious_out", 64'(out_valid && exp_q.size() == 0), 64'(0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_result", {26'h0, z, flags}, {26'h0, exp_q[0]});
        if (out_ready) begin
          sticky_m = (sticky_clr ? 6'h0 : sticky_m) | exp_q[0][5:0];
          void'(exp_q.pop_front());
        end else if (sticky_clr) sticky_m = '0;
      end else if (sticky_clr) sticky_m = '0;
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(a, b, zc, ovf, unf, inx, rnd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] ta, tb_, tz, input logic tov, tun, tix, input round_values tm);
    a = ta; b = tb_; zc = tz; ovf = tov; unf = tun; inx = tix; rnd = tm;
  endtask

  task automatic run_one(input string tag, input logic [31:0] ta, tb_, tz,
                         input logic tov, tun, tix, input round_values tm,
                         input logic [31:0] ez, input logic [5:0] ef);
    set_ops(ta, tb_, tz, tov, tun, tix, tm);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
    step();
    chk({tag, "_lat2"}, 64'(out_valid), 64'(1));
    chk({tag, "_z"}, 64'(z), 64'(ez));
    chk({tag, "_flags"}, 64'(flags), 64'(ef));
    step();
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] held_z;
    int n;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_z", 64'(z), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    chk("rst_sticky", 64'(sticky), 64'(0));
    step();
    rst = 1'b0;
    step();

    run_one("one_x_inf", 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 0, 0, 0, IEEE_near,
            32'h7F80_0000, 6'b010000);
    run_one("zero_x_inf", 32'h0000_0000, 32'hFF80_0000, 32'h0, 0, 0, 1, IEEE_near,
            32'h7FC0_0000, 6'b001000);
`ifdef FP_NAN_PROPAGATE_EN
    run_one("nan_prop", 32'h7F80_0001, 32'hFF80_0000, 32'h0, 0, 0, 0, IEEE_near,
            32'h7FC0_0001, 6'b001000);
`endif
    run_one("ovf_pinf_neg", 32'hBF80_0000, 32'h3F80_0000, 32'h0, 1, 0, 0, IEEE_pinf,
            32'hFF7F_FFFF, 6'b000011);
    run_one("unf_away_pos", 32'h3F80_0000, 32'h3F80_0000, 32'h0, 0, 1, 0, away_zero,
            32'h0080_0000, 6'b000101);
    run_one("ovf_beats_unf", 32'h3F80_0000, 32'h4000_0000, 32'h0, 1, 1, 0, IEEE_near,
            32'h7F80_0000, 6'b010011);
    run_one("zc_denorm", 32'h3F80_0000, 32'hBF80_0000, 32'h8000_0001, 0, 0, 0, IEEE_near,
            32'h8000_0000, 6'b100100);

    // Backpressure: fill both stages, hold, then release.
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_ops(rand_fp(), rand_fp(), rand_fp(), 0, 0, 1, IEEE_near); step();
    set_ops(rand_fp(), rand_fp(), rand_fp(), 1, 0, 0, IEEE_zero); step();
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    set_ops(rand_fp(), rand_fp(), rand_fp(), 0, 1, 0, IEEE_ninf);
    held_z = z;
    step();
    chk("bp_z_hold", 64'(z), 64'(held_z));
    step();
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin step(); n++; end
    step();
    set_ops(rand_fp(), rand_fp(), rand_fp(), 0, 0, 0, away_zero);
    n = 0;
    while (!in_ready && n < 10) begin step(); n++; end
    step();
    drain();

    // Sticky accumulation and clear-before-OR.
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    run_one("sticky_ovf", 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1, 0, 0, IEEE_near,
            32'h7F80_0000, 6'b010011);
    chk("sticky_after_ovf", 64'(sticky), 64'(6'b010011));
    set_ops(32'h0000_0000, 32'h3F80_0000, 32'h0, 0, 0, 0, IEEE_near);
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    sticky_clr = 1'b1; out_ready = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("sticky_clr_hs", 64'(sticky), 64'(6'b100000));

    // Reset with data in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops(rand_fp(), rand_fp(), rand_fp(), 1'($urandom), 1'($urandom), 1'($urandom),
              round_values'($urandom_range(0, 5)));
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_sticky", 64'(sticky), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      sticky_clr = ($urandom_range(0, 15) == 0);
      set_ops(rand_fp(), rand_fp(), rand_fp(), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), 1'($urandom), round_values'($urandom_range(0, 5)));
      step();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_mult_exception_pipe.md
Name: fp_mult_exception_pipe

Overview:
- Parametrised, pipelined exception/status stage for the floating-point multiplier datapath; sits between the normalise/round stage and the result register.
- Classifies operands and the raw rounded product (NaN distinct from Inf), selects the special-case result per rounding mode, and produces per-operation and sticky IEEE status flags.
- Uses a valid/ready handshake with full backpressure.

Parameters:
- EXP_W, 8, exponent width; must be >= 2.
- MAN_W, 23, stored mantissa width; must be >= 2.
- W, 1+EXP_W+MAN_W, word width; localparam, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  stage can accept
- a  in  W  operand A
- b  in  W  operand B
- z_calc  in  W  raw rounded product
- overflow  in  1  datapath overflow
- underflow  in  1  datapath underflow
- inexact  in  1  datapath inexact
- round  in  round_values  rounding mode (IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- z  out  W  final result
- flags  out  6  {zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f} for the current result
- sticky_flags  out  6  OR-accumulated flags of all accepted results
- sticky_clr  in  1  synchronous clear of sticky_flags

Behaviour:
- Pipeline: two registered stages.
  - S1 registers the operand classes, the sign (a[W-1]^b[W-1]), the inputs and the mode.
  - S2 registers z, flags and out_valid.
  - Latency is exactly 2 cycles with no stall.
- Handshake:
  - Stage k loads when it is empty or its content advances. in_ready = !v1 | !v2 | out_ready (combinational).
  - While out_valid && !out_ready, z and flags hold stable.
  - Full throughput is 1 result/cycle.
- Reset: v1, v2, out_valid, z, flags and sticky_flags go to 0; in_ready = 1. Reset mid-operation discards in-flight data.
- Classes:
  - ZERO: exp == 0; denormals are flushed to zero.
  - INF: exp all ones, man == 0.
  - NAN: exp all ones, man != 0.
  - NORM: otherwise.
- Result selection, with s the product sign:
  - Any NaN operand, or ZERO×INF: canonical qNaN {0, all ones, 1, 0...}; nan_f=1; inexact_f=0.
  - INF×{INF,NORM}: {s, Inf}; inf_f=1.
  - ZERO×{ZERO,NORM}: {s, 0}; zero_f=1.
  - NORM×NORM, overflow:
    - Inf for IEEE_near, near_up, away_zero.
    - MaxNorm {s, all ones-1, all ones} for IEEE_zero.
    - IEEE_pinf: +Inf if s=0, -MaxNorm if s=1.
    - IEEE_ninf: the mirror of IEEE_pinf.
    - huge_f=1; inf_f=1 when the result is Inf.
  - NORM×NORM, underflow:
    - MinNorm {s, 0...01, 0} for away_zero, for IEEE_pinf with s=0, and for IEEE_ninf with s=1.
    - Otherwise {s, 0} with zero_f=1.
    - tiny_f=1.
  - NORM×NORM, no overflow or underflow flag:
    - z_calc class ZERO: handled as the underflow case, except tiny_f = |z_calc man.
    - z_calc class INF or NAN: {s, Inf}; inf_f=1; huge_f=1.
    - Otherwise z = z_calc.
  - For all NORM×NORM cases, inexact_f = inexact | overflow | underflow.
- Priority: overflow wins over underflow if both are asserted.
- Sticky:
  - On each output handshake, sticky_flags |= flags.
  - sticky_clr in the same cycle as a handshake: the result is the new flags only, because clear is applied before OR.

Optional Feature:
- FP_NAN_PROPAGATE_EN.
- When defined: a NaN operand propagates its own payload, quietened with man MSB forced to 1. A is preferred if both operands are NaN. ZERO×INF still yields the canonical qNaN.
- When undefined: every NaN result is the canonical qNaN.

Decomposition:
- Package fp_exc_pkg holds:
  - fp_class_t enum {ZERO, INF, NAN, NORM};
  - the flag-index constants;
  - the canonical-constant functions (qnan, inf, maxnorm, minnorm), parametrised by EXP_W and MAN_W.
- round_values is imported from round_enum_pkg.
- One sub-module, fp_classify (combinational, parametrised), is instantiated three times in S1.

Test Plan (FP32, IEEE_near unless stated):
- a=0x3F800000, b=0x7F800000, z_calc=0x7F800000 -> 2 cycles later z=0x7F800000, flags: inf_f=1 only.
- a=0x00000000, b=0xFF800000 -> z=0x7FC00000, nan_f=1, inexact_f=0; with FP_NAN_PROPAGATE_EN and a=0x7F800001 -> z=0x7FC00001.
- NORM×NORM, overflow=1, s=1, round=IEEE_pinf -> z=0xFF7FFFFF, huge_f=1, inf_f=0, inexact_f=1.
- NORM×NORM, underflow=1, s=0, round=away_zero -> z=0x00800000, tiny_f=1, zero_f=0.
- Back-to-back 4 inputs with out_ready low for cycles 2-4 -> in_ready drops once both stages are full, z held stable, no loss or duplication, order preserved.
- Overflow result accepted, then sticky_clr asserted together with a handshake of a zero result -> sticky_flags=zero_f only; rst mid-stream -> out_valid=0 and sticky_flags=0 immediately.
